// File: rtl/sdram_arbiter_if.sv
// Request/command bundle between the bus masters, the arbiter and the SDRAM controller.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid may not drop and payload may not change until that edge; ready may depend on valid.
interface sdram_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int W_ADDR = 25,
  parameter int W_LEN  = 4
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*W_ADDR-1:0] req_addr;
  logic [N_REQ*W_LEN-1:0]  req_len;
  logic                    req_urgent;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [W_ADDR-1:0]       cmd_addr;
  logic [W_LEN-1:0]        cmd_len;
  logic                    ctrl_done;
  logic [N_REQ-1:0]        grant;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_urgent, cmd_ready, ctrl_done,
    input  req_ready, cmd_valid, cmd_write, cmd_addr, cmd_len, grant
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_urgent, cmd_ready, ctrl_done,
    output req_ready, cmd_valid, cmd_write, cmd_addr, cmd_len, grant
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Burst arbiter for the shared SDRAM command port: urgent port 0, then starvation
// override, then round-robin. Grant is held from decision until the controller's ctrl_done.
module sdram_arbiter #(
  parameter int N_REQ    = 3,
  parameter int W_ADDR   = 25,
  parameter int W_LEN    = 4,
  parameter int MAX_SKIP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sdram_arbiter_if.slave bus,
  output logic [1:0]     dbg_state
);
  localparam int W_PTR = $clog2(N_REQ);
  localparam logic [3:0] SKIP_MAX = 4'(MAX_SKIP);
  localparam logic [W_PTR:0] N_SUM = (W_PTR + 1)'(N_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_t;

  state_t             state, next_state;
  logic               accept;
  logic [W_PTR-1:0]   rr_ptr, owner;
  logic [3:0]         skip_cnt [N_REQ];

  logic               urgent_hit, starve_hit;
  logic [W_PTR-1:0]   starve_idx, rr_off, rr_idx, win;
  logic [2*N_REQ-1:0] rr_view;
  logic [W_PTR:0]     rr_sum, rr_wrap, own_inc;
  logic               sel_write;
  logic [W_ADDR-1:0]  sel_addr;
  logic [W_LEN-1:0]   sel_len;

  // Winner selection; all loops scan downward so the last hit is the lowest index/offset.
  always_comb begin
    urgent_hit = bus.req_urgent & bus.req_valid[0];
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && skip_cnt[i] == SKIP_MAX) begin
        starve_hit = 1'b1;
        starve_idx = W_PTR'(i);
      end
    end
    rr_view = {bus.req_valid, bus.req_valid} >> rr_ptr;
    rr_off  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rr_view[k]) rr_off = W_PTR'(k);
    end
    rr_sum  = {1'b0, rr_ptr} + {1'b0, rr_off};
    rr_wrap = rr_sum - N_SUM;
    rr_idx  = (rr_sum >= N_SUM) ? rr_wrap[W_PTR-1:0] : rr_sum[W_PTR-1:0];
    win     = urgent_hit ? '0 : (starve_hit ? starve_idx : rr_idx);
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == W_PTR'(i)) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*W_ADDR +: W_ADDR];
        sel_len   = bus.req_len[i*W_LEN +: W_LEN];
      end
    end
    own_inc = {1'b0, owner} + (W_PTR + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|bus.req_valid) next_state = ISSUE;
      ISSUE:   if (bus.cmd_ready)  next_state = BUSY;
      BUSY:    if (bus.ctrl_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept        = (state == ISSUE) && bus.cmd_ready;
    bus.cmd_valid = (state == ISSUE);
    bus.req_ready = accept ? bus.grant : '0;
    dbg_state     = state;
  end

  // Decision is registered in IDLE; rr_ptr and skip counters move only at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.grant     <= '0;
      bus.cmd_write <= 1'b0;
      bus.cmd_addr  <= '0;
      bus.cmd_len   <= '0;
      owner         <= '0;
      rr_ptr        <= '0;
      for (int i = 0; i < N_REQ; i++) skip_cnt[i] <= '0;
    end else begin
      if (state == IDLE && |bus.req_valid) begin
        bus.grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
        bus.cmd_write <= sel_write;
        bus.cmd_addr  <= sel_addr;
        bus.cmd_len   <= sel_len;
        owner         <= win;
      end else if (state == BUSY && bus.ctrl_done) begin
        bus.grant <= '0;
      end
      if (accept) rr_ptr <= (own_inc >= N_SUM) ? '0 : own_inc[W_PTR-1:0];
      for (int i = 0; i < N_REQ; i++) begin
        if (!bus.req_valid[i]) begin
          skip_cnt[i] <= '0;
        end else if (accept) begin
          if (owner == W_PTR'(i))          skip_cnt[i] <= '0;
          else if (skip_cnt[i] != SKIP_MAX) skip_cnt[i] <= skip_cnt[i] + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios followed by randomized bursts, each decision
// predicted by a transaction-level policy model (urgent, starvation, rotation).
module tb_sdram_arbiter;
  localparam int N_REQ = 3, W_ADDR = 25, W_LEN = 4, MAX_SKIP = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_BUSY = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  sdram_arbiter_if #(.N_REQ(N_REQ), .W_ADDR(W_ADDR), .W_LEN(W_LEN)) bus ();

  sdram_arbiter #(.N_REQ(N_REQ), .W_ADDR(W_ADDR), .W_LEN(W_LEN), .MAX_SKIP(MAX_SKIP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W_ADDR-1:0] p_addr  [N_REQ];
  logic [W_LEN-1:0]  p_len   [N_REQ];
  logic              p_write [N_REQ];
  logic [31:0]       exp_q[$];
  int                m_rr;
  int                m_skip [N_REQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int w);
    return N_REQ'(1) << w;
  endfunction

  // Policy model: urgent port 0, else lowest starved port, else first valid from the pointer.
  function automatic int model_pick(input logic [N_REQ-1:0] v, input logic urg);
    if (urg && v[0]) return 0;
    for (int i = 0; i < N_REQ; i++) if (v[i] && m_skip[i] == MAX_SKIP) return i;
    for (int k = 0; k < N_REQ; k++) if (v[(m_rr + k) % N_REQ]) return (m_rr + k) % N_REQ;
    return 0;
  endfunction

  task automatic model_accept(input int w, input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) begin
      if (i == w)    m_skip[i] = 0;
      else if (v[i]) m_skip[i] = (m_skip[i] < MAX_SKIP) ? m_skip[i] + 1 : MAX_SKIP;
    end
    m_rr = (w + 1) % N_REQ;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_REQ; i++) if (!bus.req_valid[i]) m_skip[i] = 0;
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_addr[i*W_ADDR +: W_ADDR] = p_addr[i];
      bus.req_len[i*W_LEN +: W_LEN]    = p_len[i];
      bus.req_write[i]                 = p_write[i];
    end
  endtask

  task automatic set_port(input int i, input logic [W_ADDR-1:0] a, input logic [W_LEN-1:0] l,
                          input logic wr);
    p_addr[i] = a; p_len[i] = l; p_write[i] = wr;
    drive_fields();
  endtask

  task automatic rand_port(input int i);
    set_port(i, W_ADDR'($urandom), W_LEN'($urandom), 1'($urandom));
  endtask

  task automatic set_valid(input logic [N_REQ-1:0] m);
    bus.req_valid = m;
    model_clear();
  endtask

  // Replace the winner's request and possibly raise idle ports; pending losers are untouched.
  task automatic refresh(input int w);
    rand_port(w);
    bus.req_valid[w] = 1'($urandom_range(0, 1));
    for (int i = 0; i < N_REQ; i++) begin
      if (i != w && !bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
        rand_port(i);
        bus.req_valid[i] = 1'b1;
      end
    end
    model_clear();
  endtask

  // Starts at a negedge with the arbiter idle; returns at the first BUSY negedge.
  task automatic issue(input int bp, input logic noise, input bit rnd, output int w);
    logic [N_REQ-1:0] v, g;
    if (bus.req_valid == '0) bus.req_valid[$urandom_range(0, N_REQ-1)] = 1'b1;
    model_clear();
    v = bus.req_valid;
    exp_q.push_back(32'(model_pick(v, bus.req_urgent)));
    @(negedge clk);
    w = int'(exp_q.pop_front());
    g = onehot(w);
    check("issue_grant", 64'(bus.grant), 64'(g));
    check("grant_onehot0", 64'($onehot0(bus.grant)), 64'(1));
    check("issue_cmd_valid", 64'(bus.cmd_valid), 64'(1));
    check("issue_cmd_addr", 64'(bus.cmd_addr), 64'(p_addr[w]));
    check("issue_cmd_len", 64'(bus.cmd_len), 64'(p_len[w]));
    check("issue_cmd_write", 64'(bus.cmd_write), 64'(p_write[w]));
    check("issue_state", 64'(dbg_state), 64'(S_ISSUE));
    for (int b = 0; b < bp; b++) begin
      bus.ctrl_done = noise;
      @(negedge clk);
      bus.ctrl_done = 1'b0;
      check("hold_grant", 64'(bus.grant), 64'(g));
      check("hold_cmd_valid", 64'(bus.cmd_valid), 64'(1));
      check("hold_cmd_addr", 64'(bus.cmd_addr), 64'(p_addr[w]));
      check("hold_req_ready", 64'(bus.req_ready), 64'(0));
    end
    bus.ctrl_done = noise;
    bus.cmd_ready = 1'b1;
    #1;
    check("accept_req_ready", 64'(bus.req_ready), 64'(g));
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    bus.ctrl_done = 1'b0;
    check("busy_cmd_valid", 64'(bus.cmd_valid), 64'(0));
    check("busy_grant", 64'(bus.grant), 64'(g));
    check("busy_req_ready", 64'(bus.req_ready), 64'(0));
    check("busy_state", 64'(dbg_state), 64'(S_BUSY));
    model_accept(w, v);
    if (rnd) refresh(w);
  endtask

  task automatic finish_burst(input int w, input int busy);
    for (int b = 0; b < busy; b++) begin
      @(negedge clk);
      check("busy_hold_grant", 64'(bus.grant), 64'(onehot(w)));
    end
    bus.ctrl_done = 1'b1;
    @(negedge clk);
    bus.ctrl_done = 1'b0;
    check("done_grant", 64'(bus.grant), 64'(0));
    check("done_state", 64'(dbg_state), 64'(S_IDLE));
    check("done_cmd_valid", 64'(bus.cmd_valid), 64'(0));
  endtask

  // lit >= 0 additionally pins the winner to a hand-derived port.
  task automatic burst(input int bp, input logic noise, input bit rnd, input int busy, input int lit);
    int w;
    issue(bp, noise, rnd, w);
    if (lit >= 0) check("directed_grant", 64'(bus.grant), 64'(onehot(lit)));
    finish_burst(w, busy);
  endtask

  initial begin
    int w;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_len = '0;
    bus.req_urgent = 1'b0; bus.cmd_ready = 1'b0; bus.ctrl_done = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      p_addr[i] = '0; p_len[i] = '0; p_write[i] = 1'b0; m_skip[i] = 0;
    end
    m_rr = 0;
    rst_n = 1'b0;
    #1;
    check("rst_grant", 64'(bus.grant), 64'(0));
    check("rst_cmd_valid", 64'(bus.cmd_valid), 64'(0));
    check("rst_cmd_addr", 64'(bus.cmd_addr), 64'(0));
    check("rst_cmd_len", 64'(bus.cmd_len), 64'(0));
    check("rst_cmd_write", 64'(bus.cmd_write), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", 64'(dbg_state), 64'(S_IDLE));

    // Single port with a known payload.
    set_port(1, 25'h12345, 4'd7, 1'b1);
    set_valid(3'b010);
    burst(0, 1'b0, 0, 3, 1);

    // Rotation with everyone pending; pointer sits at 2 after port 1.
    set_valid(3'b111);
    burst(0, 1'b0, 0, 3, 2);
    burst(0, 1'b0, 0, 3, 0);
    burst(0, 1'b0, 0, 3, 1);
    burst(0, 1'b0, 0, 3, 2);
    burst(0, 1'b0, 0, 3, 0);
    burst(0, 1'b0, 0, 3, 1);

    // Urgent override with the pointer at 1, then rotation resumes at 1.
    set_valid(3'b001);
    burst(0, 1'b0, 0, 2, 0);
    set_valid(3'b111);
    bus.req_urgent = 1'b1;
    burst(0, 1'b0, 0, 2, 0);
    bus.req_urgent = 1'b0;
    burst(0, 1'b0, 0, 2, 1);
    burst(0, 1'b0, 0, 2, 2);

    // Starvation: port 2 passed over six times (counter saturates), then it beats rotation.
    set_valid(3'b101);
    bus.req_urgent = 1'b1;
    for (int n = 0; n < 6; n++) burst(0, 1'b0, 0, 1, 0);
    set_valid(3'b111);
    bus.req_urgent = 1'b0;
    burst(0, 1'b0, 0, 1, 2);
    burst(0, 1'b0, 0, 1, 0);

    // Backpressure with spurious ctrl_done during ISSUE and at acceptance.
    set_valid(3'b100);
    burst(10, 1'b1, 0, 2, 2);

    // Asynchronous reset during BUSY, then rotation restarts from port 0's pointer.
    set_valid(3'b010);
    issue(0, 1'b0, 0, w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_grant", 64'(bus.grant), 64'(0));
    check("midrst_cmd_valid", 64'(bus.cmd_valid), 64'(0));
    check("midrst_cmd_addr", 64'(bus.cmd_addr), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(S_IDLE));
    m_rr = 0;
    for (int i = 0; i < N_REQ; i++) m_skip[i] = 0;
    set_valid(3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    set_valid(3'b110);
    burst(0, 1'b0, 0, 2, 1);

    // Randomized traffic against the policy model.
    for (int i = 0; i < N_REQ; i++) rand_port(i);
    set_valid(N_REQ'($urandom));
    for (int n = 0; n < 60; n++) begin
      bus.req_urgent = ($urandom_range(0, 3) == 0);
      burst($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1, $urandom_range(0, 4), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between N_REQ bus masters: display scanout, CPU/cache refill, and DMA.
- Grants one burst at a time and holds the grant until the controller reports the burst complete.
- The one-hot grant steers the external data-beat muxes.
- Policy, highest first: urgent override for port 0 (scanout FIFO low), then a starvation override, then round-robin.

Parameters:
- N_REQ, 3, number of requesters (2..8); port 0 is the urgent-capable port.
- W_ADDR, 25, SDRAM halfword address width.
- W_LEN, 4, burst length field width; value = beats-1, passed through unmodified.
- MAX_SKIP, 4, number of times a pending port may be passed over before it is forced (1..15).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, N_REQ, per-port request pending; must stay high with fields stable until req_ready.
- req_ready, output, N_REQ, per-port one-cycle accept pulse.
- req_write, input, N_REQ, per-port 1 = write burst.
- req_addr, input, N_REQ*W_ADDR, per-port start address; port i occupies bits [i*W_ADDR +: W_ADDR].
- req_len, input, N_REQ*W_LEN, per-port burst length-1; packed the same way as req_addr.
- req_urgent, input, 1, port 0 urgency (scanout FIFO below watermark).
- cmd_valid, output, 1, command to controller valid.
- cmd_ready, input, 1, controller accepts command.
- cmd_write, output, 1, registered copy of the winner's req_write.
- cmd_addr, output, W_ADDR, registered copy of the winner's req_addr.
- cmd_len, output, W_LEN, registered copy of the winner's req_len.
- ctrl_done, input, 1, controller pulse: last data beat of the current burst transferred.
- grant, output, N_REQ, one-hot owner of the controller; zero when idle.

Behaviour:
- Reset state: grant=0, cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_len=0, req_ready=0, state=IDLE, rr_ptr=0, all skip counters 0.
- State IDLE, no req_valid bit set: remain in IDLE.
- State IDLE, any req_valid set: pick winner w, load grant=onehot(w), latch cmd_* from port w, set cmd_valid=1, go to ISSUE.
  - Registered decision: cmd_valid rises one cycle after req_valid is first seen.
- Winner selection, in priority order:
  - (a) req_urgent && req_valid[0] -> port 0.
  - (b) otherwise, the lowest-index valid port whose skip_cnt == MAX_SKIP.
  - (c) otherwise, the first valid port searching upward from rr_ptr, wrapping N_REQ-1 -> 0.
- State ISSUE:
  - Hold cmd_* and grant stable while cmd_ready=0.
  - On cmd_valid && cmd_ready: req_ready[w] is high that same cycle (combinational: cmd_ready & grant & ISSUE); cmd_valid drops next cycle; go to BUSY.
- State BUSY: grant is held; on ctrl_done, grant clears next cycle and state returns to IDLE.
  - IDLE→ISSUE takes at least one cycle, so the minimum gap between bursts is 1 cycle.
- ctrl_done outside BUSY is ignored, including in the same cycle as acceptance.
- rr_ptr update: at acceptance, rr_ptr = (w+1) mod N_REQ, regardless of which rule chose w.
- skip_cnt[i] update: at each acceptance of w != i with req_valid[i]=1, skip_cnt[i] increments, saturating at MAX_SKIP.
- skip_cnt clear: skip_cnt[w] clears at its own acceptance; skip_cnt[i] also clears whenever req_valid[i]=0.
- Urgent versus starvation: urgent outranks starvation, so a starved port may exceed MAX_SKIP only while port 0 stays urgent.
- Unsupported cases:
  - Dropping req_valid before req_ready is a protocol violation; behaviour is unspecified but the FSM must not lock up.
  - Simultaneous req_urgent without req_valid[0] has no effect.
- Asynchronous reset mid-burst returns to the reset state immediately; the controller is reset by the same rst_n.

Test Plan:
- Single port: req_valid=3'b010, addr=0x12345, len=7, cmd_ready=1 -> cmd_valid at cycle+1 with cmd_addr=0x12345, cmd_len=7; req_ready[1] for 1 cycle; grant=3'b010 until 1 cycle after ctrl_done.
- Round-robin: all three ports valid continuously, urgent=0, ctrl_done 4 cycles after each accept -> grant order 0,1,2,0,1,2; at most one grant bit set at any time.
- Urgent: ports 1,2 valid, rr_ptr=1, port 0 valid with urgent=1 -> port 0 wins next; drop urgent -> rotation resumes at port 1.
- Starvation: MAX_SKIP=4, ports 0 and 2 valid, urgent=1 except during port 0's fifth IDLE decision -> port 2 granted at that decision, skip_cnt[2] back to 0.
- Backpressure: cmd_ready=0 for 10 cycles -> cmd_* and grant stable, req_ready=0; cmd_ready=1 -> single req_ready pulse.
- Reset: assert rst_n low during BUSY -> grant=0, cmd_valid=0 immediately; after release, first winner is chosen from rr_ptr=0.
